// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard host path.
// Used by the host transmitter and reusable by the receive side.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_state_t;

  // Start, 8 data, parity, stop: the device generates 11 clocks per host frame.
  localparam int FRAME_BITS = 11;
  // The host changes data on every falling edge except the one for the start bit.
  localparam int SEND_FALLS = FRAME_BITS - 1;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // Odd parity: returns the bit that makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter for one PS/2 line.
// The filtered output idles high and only follows a sustained change.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_reg;
  logic [CW-1:0] run_reg;
  logic          filt_reg;

  // run_reg counts consecutive synchronized samples that disagree with the
  // filtered value; a single agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= 2'b11;
      run_reg  <= '0;
      filt_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], line_raw};
      if (sync_reg[1] == filt_reg) begin
        run_reg <= '0;
      end else if (run_reg == CW'(FILTER_LEN - 1)) begin
        filt_reg <= sync_reg[1];
        run_reg  <= '0;
      end else begin
        run_reg <= run_reg + 1'b1;
      end
    end
  end

  assign line_filt = filt_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame,
// device ACK check and timeout; drives the open-drain lines via pull-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Fast_Clock,
  input  logic       Reset,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Start,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_Error,
  input  logic       PS2_KB_Clk,
  input  logic       PS2_KB_Data,
  output logic       KB_Clk_OE,
  output logic       KB_Data_OE
);

  localparam int T_A       = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int TIMER_MAX = (TIMEOUT_CYCLES > T_A) ? TIMEOUT_CYCLES : T_A;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  logic [1:0] raw_lines;
  logic [1:0] filt_lines;
  logic       clk_filt;
  logic       data_filt;

  assign raw_lines = {PS2_KB_Data, PS2_KB_Clk};

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
    ) u_filt (
      .clk      (Fast_Clock),
      .srst     (Reset),
      .line_raw (raw_lines[gi]),
      .line_filt(filt_lines[gi])
    );
  end

  assign clk_filt  = filt_lines[0];
  assign data_filt = filt_lines[1];

  ps2_state_t    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [9:0]    shift_reg, shift_next;
  logic          clk_prev_reg;
  logic          clk_oe_reg, clk_oe_next;
  logic          data_oe_reg, data_oe_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          error_reg, error_next;
  logic          fall;
  logic          timed_out;

  assign fall      = clk_prev_reg & ~clk_filt;
  assign timed_out = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '1;
      clk_prev_reg <= 1'b1;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      clk_prev_reg <= clk_filt;
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg + 1'b1;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    data_oe_next = data_oe_reg;

    unique case (state_reg)
      // DONE and ERR already report busy low, so a new request is taken there too.
      IDLE, DONE, ERR: begin
        state_next   = IDLE;
        timer_next   = '0;
        data_oe_next = 1'b0;
        if (Tx_Start) begin
          state_next = INHIBIT;
          shift_next = {1'b1, odd_parity(Tx_Data), Tx_Data};
        end
      end
      INHIBIT: begin
        if (timer_reg == TW'(INHIBIT_CYCLES - 1)) begin
          state_next   = REQUEST;
          timer_next   = '0;
          data_oe_next = 1'b1;
        end
      end
      REQUEST: begin
        if (timer_reg == TW'(REQ_CYCLES - 1)) begin
          state_next   = SEND;
          timer_next   = '0;
          bit_cnt_next = '0;
        end
      end
      SEND: begin
        if (timed_out) begin
          state_next = ERR;
        end else if (fall) begin
          data_oe_next = ~shift_reg[0];
          shift_next   = {1'b1, shift_reg[9:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 4'(SEND_FALLS - 1)) begin
            state_next = ACK;
          end
        end
      end
      ACK: begin
        if (timed_out) begin
          state_next = ERR;
        end else if (fall) begin
          state_next = data_filt ? ERR : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (timed_out) begin
          state_next = ERR;
        end else if (clk_filt && data_filt) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase

    // An aborted transfer must let go of the data line in the same cycle.
    if (state_next == ERR) begin
      data_oe_next = 1'b0;
    end

    clk_oe_next = (state_next == INHIBIT) || (state_next == REQUEST);
    busy_next   = (state_next == INHIBIT) || (state_next == REQUEST) ||
                  (state_next == SEND) || (state_next == ACK) ||
                  (state_next == WAIT_IDLE);
    done_next   = (state_next == DONE);
    error_next  = (state_next == ERR);
  end

  assign Tx_Busy    = busy_reg;
  assign Tx_Done    = done_reg;
  assign Tx_Error   = error_reg;
  assign KB_Clk_OE  = clk_oe_reg;
  assign KB_Data_OE = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized bench for ps2_host_tx with a behavioural keyboard
// model that clocks the frame, samples on rising edges and optionally ACKs.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int REQ  = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       clk_oe;
  logic       data_oe;
  logic       dev_clk;
  logic       dev_data;
  logic       glitch;
  logic       ps2_clk;
  logic       ps2_data;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk  = dev_clk & ~clk_oe & ~glitch;
  assign ps2_data = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (2)
  ) dut (
    .Fast_Clock (clk),
    .Reset      (rst),
    .Tx_Data    (tx_data),
    .Tx_Start   (tx_start),
    .Tx_Busy    (tx_busy),
    .Tx_Done    (tx_done),
    .Tx_Error   (tx_error),
    .PS2_KB_Clk (ps2_clk),
    .PS2_KB_Data(ps2_data),
    .KB_Clk_OE  (clk_oe),
    .KB_Data_OE (data_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_bad = 0;
  int err_bad  = 0;

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt++;
      if (tx_busy || tx_error) done_bad++;
    end
    if (tx_error) begin
      err_cnt++;
      if (tx_busy || clk_oe || data_oe) err_bad++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference frame as the keyboard sees it: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  // mode: 0 plain, 1 extra Tx_Start mid-frame, 2 reset during bit 4, 3 clock glitches
  task automatic dev_xfer(input bit ack, input int mode, output logic [10:0] frame,
                          output bit aborted);
    frame    = '0;
    aborted  = 1'b0;
    frame[0] = ps2_data;
    for (int i = 1; i <= 10; i++) begin
      cyc(HALF / 2);
      if (mode == 1 && i == 4) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0;
      end else if (mode == 3) begin
        glitch = 1'b1;
        cyc(1);
        glitch = 1'b0;
      end else begin
        cyc(1);
      end
      cyc(HALF / 2 - 1);
      dev_clk = 1'b0;
      if (mode == 2 && i == 5) begin
        cyc(10);
        rst     = 1'b1;
        dev_clk = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_clk_oe", {31'd0, clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, data_oe}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        aborted = 1'b1;
        return;
      end
      cyc(HALF);
      frame[i] = ps2_data;
      dev_clk  = 1'b1;
    end
    cyc(HALF / 2);
    if (ack) dev_data = 1'b0;
    cyc(HALF / 2);
    dev_clk = 1'b0;
    cyc(HALF);
    dev_clk = 1'b1;
    cyc(5);
    dev_data = 1'b1;
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input int mode);
    int n;
    int d0;
    int e0;
    bit aborted;
    logic [10:0] frame;
    logic [10:0] exp_frame;
    exp_frame = model_frame(d);
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = d;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    chk("busy_after_start", {31'd0, tx_busy}, 32'd1);
    n = 0;
    while (clk_oe && !data_oe && n < 100) begin
      n++;
      cyc(1);
    end
    chk("inhibit_len", n, INH);
    n = 0;
    while (clk_oe && data_oe && n < 100) begin
      n++;
      cyc(1);
    end
    chk("request_len", n, REQ);
    dev_xfer(ack, mode, frame, aborted);
    if (aborted) begin
      cyc(50);
      chk("rst_no_done", done_cnt - d0, 0);
      chk("rst_no_err", err_cnt - e0, 0);
    end else begin
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
        n++;
        cyc(1);
      end
      chk("resp_in_time", {31'd0, n < 200}, 32'd1);
      cyc(20);
      chk("frame", {21'd0, frame}, {21'd0, exp_frame});
      chk("done_pulses", done_cnt - d0, ack ? 1 : 0);
      chk("err_pulses", err_cnt - e0, ack ? 0 : 1);
      chk("idle_busy", {31'd0, tx_busy}, 32'd0);
      chk("idle_oe", {30'd0, clk_oe, data_oe}, 32'd0);
      $display("xfer data=%02h ack=%0d mode=%0d frame=%03h expected=%03h",
               d, ack, mode, frame, exp_frame);
    end
  endtask

  initial begin
    int k;
    int d0;
    int e0;
    logic [7:0] rd;
    bit rack;
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    glitch   = 1'b0;
    cyc(3);
    rst = 1'b0;
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    chk("reset_done", {31'd0, tx_done}, 32'd0);
    chk("reset_error", {31'd0, tx_error}, 32'd0);
    chk("reset_clk_oe", {31'd0, clk_oe}, 32'd0);
    chk("reset_data_oe", {31'd0, data_oe}, 32'd0);
    cyc(10);

    run_xfer(8'hED, 1'b1, 0);
    run_xfer(8'h01, 1'b1, 0);
    run_xfer(8'hA5, 1'b0, 0);

    // Device never clocks: host must give up a fixed time after releasing the clock.
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    k = 0;
    while (clk_oe && k < 100) begin
      k++;
      cyc(1);
    end
    chk("to_hold_len", k, INH + REQ);
    k = 0;
    while (!tx_error && k < 3000) begin
      k++;
      cyc(1);
    end
    chk("to_cycles", k, TMO);
    chk("to_oe", {30'd0, clk_oe, data_oe}, 32'd0);
    chk("to_busy", {31'd0, tx_busy}, 32'd0);
    cyc(5);
    chk("to_err_pulses", err_cnt - e0, 1);
    chk("to_done_pulses", done_cnt - d0, 0);
    $display("xfer timeout cycles=%0d expected=%0d", k, TMO);

    run_xfer(8'hED, 1'b1, 1);
    cyc(100);
    chk("ignored_start_idle", {30'd0, clk_oe, tx_busy}, 32'd0);

    run_xfer(8'hED, 1'b1, 2);
    cyc(50);
    run_xfer(8'hFF, 1'b1, 0);
    run_xfer(8'hED, 1'b1, 3);

    for (int i = 0; i < 4; i++) begin
      rd   = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      run_xfer(rd, rack, 0);
    end

    chk("done_with_busy_or_err", done_bad, 0);
    chk("err_with_busy_or_oe", err_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the send-side counterpart to the keyboard receive path in IO_Module.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the standard request-to-send sequence: inhibit clock, start bit, 8 data bits LSB-first, odd parity, stop, device ACK.
- Drives the open-drain PS2_KB_Clk/PS2_KB_Data lines through active-high pull-low enables; the top level ties them to tri-state pads.

Parameters:
INHIBIT_CYCLES, 5000, cycles clock is held low before start (100 us at 50 MHz)
REQ_CYCLES, 50, cycles clock and data are both held low before clock release
TIMEOUT_CYCLES, 1000000, max cycles from clock release to return of idle lines (20 ms)
FILTER_LEN, 8, consecutive equal samples required to change a filtered line value

Ports:
Fast_Clock  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-high
Tx_Data  in  8  byte to send; captured when Tx_Start is accepted
Tx_Start  in  1  single-cycle request; accepted only when Tx_Busy=0
Tx_Busy  out  1  high from the cycle after acceptance until Done/Error
Tx_Done  out  1  one-cycle pulse: device ACKed and lines returned to idle
Tx_Error  out  1  one-cycle pulse: no ACK, or timeout
PS2_KB_Clk  in  1  raw clock line (async)
PS2_KB_Data  in  1  raw data line (async)
KB_Clk_OE  out  1  1 = pull clock line low
KB_Data_OE  out  1  1 = pull data line low

Behaviour:
- All outputs registered. Reset values: Tx_Busy=0, Tx_Done=0, Tx_Error=0, KB_Clk_OE=0, KB_Data_OE=0, state=IDLE, filtered lines=1.
- Input conditioning: 2-FF synchronizer, then filter. The filtered value changes only after FILTER_LEN identical synchronized samples. Falling edge is filtered clock 1->0.
- Accept: in IDLE with Tx_Start=1, latch shift register {stop=1, parity=~^Tx_Data, Tx_Data}. Parity is odd: 0x01 -> 0, 0xED -> 1, 0x00 -> 1.
- IDLE: both OE=0.
  - Tx_Start -> INHIBIT.
  - Tx_Start while busy is ignored, with no effect on the current transfer.
- INHIBIT: KB_Clk_OE=1 for exactly INHIBIT_CYCLES cycles, then -> REQUEST.
- REQUEST: KB_Clk_OE=1, KB_Data_OE=1 (start bit 0) for REQ_CYCLES cycles, then -> SEND.
  - On entry to SEND: KB_Clk_OE=0; clear timeout counter and bit counter.
- SEND: data line is updated on each filtered falling edge; the device samples on rising edges.
  - Falling edges 1-8: KB_Data_OE = ~Tx_Data[n], n=0..7.
  - Falling edge 9: KB_Data_OE = ~parity.
  - Falling edge 10: KB_Data_OE=0 (stop=1, line released). -> ACK.
- ACK: on the next falling edge, sample filtered data.
  - Data 0 -> WAIT_IDLE.
  - Data 1 -> ERR.
- WAIT_IDLE: wait until filtered clock=1 and filtered data=1, then -> DONE.
- DONE: Tx_Done=1 for one cycle -> IDLE.
- ERR: Tx_Error=1 for one cycle; both OE=0 -> IDLE.
- Timeout counter runs in SEND/ACK/WAIT_IDLE. On reaching TIMEOUT_CYCLES -> ERR from any of those states, releasing both lines immediately.
- Exactly one of Tx_Done/Tx_Error pulses per accepted transfer. Tx_Busy falls in the same cycle as the pulse.
- Reset mid-operation (any state): on the next edge return to IDLE with both OE=0, no Done/Error pulse, filters re-init to 1.
- Bit counter is 4 bits; the shift register shifts right on each SEND falling edge.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE, DONE, ERR)
  - odd-parity function
  - frame-length constant (11 device clocks)
  - command constants (CMD_SET_LEDS=0xED, CMD_RESET=0xFF, ACK_BYTE=0xFA)
- Sub-module ps2_line_filter (synchronizer + FILTER_LEN filter, reset value 1), instantiated once per line. The keyboard receive path can reuse it.

Test Plan:
(Use a bench device model with INHIBIT_CYCLES=20, REQ_CYCLES=4, FILTER_LEN=2, TIMEOUT_CYCLES=2000, device clock half-period 40 cycles.)
1. Tx_Data=0xED with Tx_Start pulse -> KB_Clk_OE=1 for exactly 20 cycles, then 4 cycles with both OE=1. The model samples bits on rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs low -> Tx_Done pulse, Tx_Error=0, Busy=0.
2. Tx_Data=0x01 -> model sees data bits 1,0,0,0,0,0,0,0 and parity 0; Tx_Done pulse.
3. Model leaves data high at the ACK edge -> Tx_Error single pulse, Tx_Done never asserted, both OE=0.
4. Model never clocks after release -> Tx_Error exactly TIMEOUT_CYCLES (2000) cycles after clock release, both OE=0, Busy=0.
5. Second Tx_Start=0x55 during 0xED transfer -> ignored; model receives only 0xED. Separately, Reset during bit 4 -> next cycle OE=0/0, Busy=0, no pulse; a following 0xFF transfer completes with parity 1.
6. Inject 1-cycle low glitches on PS2_KB_Clk during SEND -> bit counter not advanced; model still receives 0xED intact.
